// File: rtl/arith_select_pipe.sv
// Two-stage add/sub/multiply/MAC pipeline with valid/ready handshakes on both sides.
// S1 registers the accepted beat; S2 computes and registers result, ovf and the accumulator.
module arith_select_pipe #(
    parameter int WIDTH = 4,
    parameter int GUARD = 4,
    localparam int RES_W = 2 * WIDTH + GUARD
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] result,
    output logic             ovf
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_MAC = 2'b11
    } op_e;

    // Handshake: a beat moves on a rising edge where its valid and the matching
    // ready are both high. Only a full S2 facing a not-ready consumer stalls the
    // pipe, and then S1, S2 and the accumulator all freeze together, so in_ready
    // is simply the inverse of that stall condition.
    logic stall;

    logic             s1_valid;
    op_e              s1_mode;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_clr;

    logic             s2_valid;
    logic [RES_W-1:0] result_q;
    logic             ovf_q;
    logic [RES_W-1:0] acc;

    logic [2*WIDTH-1:0] prod;
    logic [RES_W-1:0]   a_ext;
    logic [RES_W-1:0]   b_ext;
    logic [RES_W-1:0]   prod_ext;
    logic [RES_W-1:0]   acc_base;
    logic [RES_W-1:0]   sum_add;
    logic [RES_W-1:0]   diff;
    logic [RES_W:0]     mac_sum;
    logic [RES_W-1:0]   calc_result;
    logic               calc_ovf;

    assign stall     = s2_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = s2_valid;
    assign result    = result_q;
    assign ovf       = ovf_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_valid <= 1'b0;
            s1_mode  <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_clr   <= 1'b0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= op_e'(mode);
                s1_a    <= input1;
                s1_b    <= input2;
                s1_clr  <= acc_clr;
            end
        end
    end

    always_comb begin
        a_ext    = RES_W'(s1_a);
        b_ext    = RES_W'(s1_b);
        prod     = (2 * WIDTH)'(s1_a) * (2 * WIDTH)'(s1_b);
        prod_ext = RES_W'(prod);
        sum_add  = a_ext + b_ext;
        diff     = a_ext - b_ext;
        // acc_clr replaces the running sum with zero for this beat only.
        acc_base = s1_clr ? '0 : acc;
        mac_sum  = (RES_W + 1)'(acc_base) + (RES_W + 1)'(prod_ext);

        calc_result = '0;
        calc_ovf    = 1'b0;
        case (s1_mode)
            OP_ADD: calc_result = sum_add;
            OP_SUB: begin
                calc_result = diff;
                calc_ovf    = (s1_a < s1_b);
            end
            OP_MUL: calc_result = prod_ext;
            OP_MAC: begin
                calc_result = mac_sum[RES_W-1:0];
                calc_ovf    = mac_sum[RES_W];
            end
            default: calc_result = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s2_valid <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            acc      <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            // Output registers keep their last value across bubbles.
            if (s1_valid) begin
                result_q <= calc_result;
                ovf_q    <= calc_ovf;
                if (s1_mode == OP_MAC) begin
                    acc <= mac_sum[RES_W-1:0];
                end else if (s1_clr) begin
                    acc <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_arith_select_pipe.sv
// Directed self-checking bench for arith_select_pipe (WIDTH=4, GUARD=4, RES_W=12).
// Each task drives one scenario and compares observed results against hand-computed values.
module tb_arith_select_pipe;

    localparam int WIDTH = 4;
    localparam int GUARD = 4;
    localparam int RES_W = 2 * WIDTH + GUARD;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] result;
    logic             ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Entries are {ovf, result}.
    logic [RES_W:0] exp_q[$];
    logic [RES_W:0] obs_q[$];

    arith_select_pipe #(.WIDTH(WIDTH), .GUARD(GUARD)) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .input1   (input1),
        .input2   (input2),
        .acc_clr  (acc_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .ovf      (ovf)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 1ns after a rising edge; handshakes are sampled mid-cycle.
    always @(negedge clk_i) begin
        if (!reset_i && out_valid && out_ready) obs_q.push_back({ovf, result});
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic drive_beat(input logic [1:0] m, input int a, input int b, input logic clr);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        mode     = m;
        input1   = WIDTH'(a);
        input2   = WIDTH'(b);
        acc_clr  = clr;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk_i);
            ok = in_ready;
            step();
            if (ok) break;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL drive_beat: in_ready stayed 0 for 50 cycles, required 1");
        end
    endtask

    task automatic wait_results(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset_i   = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        mode      = 2'b00;
        input1    = 4'd1;
        input2    = 4'd1;
        acc_clr   = 1'b0;
        step();
        step();
        reset_i = 1'b0;
        idle();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        n_checks++;
        if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %0d, required 0", result); end
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_beat_dropped[%0d]: out_valid got %b, required 0", c, out_valid);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_add();
        in_valid = 1'b1;
        mode     = 2'b00;
        input1   = 4'd9;
        input2   = 4'd7;
        acc_clr  = 1'b0;
        step();
        idle();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_latency_early: out_valid got %b, required 0", out_valid); end
        step();
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency: out_valid got %b, required 1", out_valid); end
        n_checks++;
        if (result !== 12'd16) begin n_fail++; $display("FAIL add_result: got %0d, required 16", result); end
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL add_ovf: got %b, required 0", ovf); end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_single_pulse: out_valid got %b, required 0", out_valid); end
        obs_q.delete();
    endtask

    task automatic test_sub_mul();
        bit ok;
        logic [RES_W:0] got, exp;
        exp_q.push_back(13'h1FFE);
        exp_q.push_back(13'd225);
        drive_beat(2'b01, 3, 5, 1'b0);
        drive_beat(2'b10, 15, 15, 1'b0);
        idle();
        wait_results(2, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL sub_mul_timeout: got %0d results, required 2", obs_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                got = obs_q.pop_front();
                exp = exp_q.pop_front();
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL sub_mul[%0d]: got ovf=%b result=0x%03h, required ovf=%b result=0x%03h",
                             i, got[RES_W], got[RES_W-1:0], exp[RES_W], exp[RES_W-1:0]);
                end
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_mac_chain();
        bit ok;
        int v;
        logic [RES_W:0] got, exp;
        for (int i = 1; i <= 19; i++) begin
            v = (i < 19) ? 225 * i : 179;
            exp_q.push_back({(i == 19) ? 1'b1 : 1'b0, v[RES_W-1:0]});
        end
        for (int i = 1; i <= 19; i++) drive_beat(2'b11, 15, 15, (i == 1));
        idle();
        wait_results(19, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mac_timeout: got %0d results, required 19", obs_q.size());
        end else begin
            for (int i = 0; i < 19; i++) begin
                got = obs_q.pop_front();
                exp = exp_q.pop_front();
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL mac_beat[%0d]: got ovf=%b result=%0d, required ovf=%b result=%0d",
                             i + 1, got[RES_W], got[RES_W-1:0], exp[RES_W], exp[RES_W-1:0]);
                end
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back_stall();
        bit ok;
        logic [RES_W-1:0] held;
        logic [RES_W:0] got, exp;
        exp_q.push_back(13'd3);
        exp_q.push_back(13'd7);
        exp_q.push_back(13'd11);
        exp_q.push_back(13'd15);
        exp_q.push_back(13'd19);
        fork
            begin
                drive_beat(2'b00, 1, 2, 1'b0);
                drive_beat(2'b00, 3, 4, 1'b0);
                drive_beat(2'b00, 5, 6, 1'b0);
                drive_beat(2'b00, 7, 8, 1'b0);
                drive_beat(2'b00, 9, 10, 1'b0);
                idle();
            end
            begin
                repeat (3) @(posedge clk_i);
                #1;
                out_ready = 1'b0;
                @(negedge clk_i);
                held = result;
                for (int c = 0; c < 3; c++) begin
                    if (c > 0) @(negedge clk_i);
                    n_checks++;
                    if (in_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall_in_ready[%0d]: got %b, required 0", c, in_ready);
                    end
                    n_checks++;
                    if (out_valid !== 1'b1 || result !== held) begin
                        n_fail++;
                        $display("FAIL stall_hold[%0d]: got valid=%b result=%0d, required valid=1 result=%0d",
                                 c, out_valid, result, held);
                    end
                end
                step();
                out_ready = 1'b1;
            end
        join
        wait_results(5, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_timeout: got %0d results, required 5", obs_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                got = obs_q.pop_front();
                exp = exp_q.pop_front();
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL stall_order[%0d]: got ovf=%b result=%0d, required ovf=%b result=%0d",
                             i, got[RES_W], got[RES_W-1:0], exp[RES_W], exp[RES_W-1:0]);
                end
            end
        end
        repeat (3) step();
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_duplicate: got %0d extra results, required 0", obs_q.size());
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_midflight();
        bit ok;
        logic [RES_W:0] got;
        out_ready = 1'b0;
        drive_beat(2'b11, 4, 4, 1'b0);
        drive_beat(2'b11, 5, 5, 1'b0);
        idle();
        reset_i = 1'b1;
        step();
        reset_i   = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midflight_flush[%0d]: out_valid got %b, required 0", c, out_valid);
            end
            step();
        end
        obs_q.delete();
        drive_beat(2'b11, 2, 3, 1'b0);
        idle();
        wait_results(1, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midflight_timeout: got 0 results, required 1");
        end else begin
            got = obs_q.pop_front();
            n_checks++;
            if (got !== 13'd6) begin
                n_fail++;
                $display("FAIL midflight_mac: got ovf=%b result=%0d, required ovf=0 result=6",
                         got[RES_W], got[RES_W-1:0]);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_acc_clr_add();
        bit ok;
        logic [RES_W:0] got, exp;
        exp_q.push_back(13'd4);
        exp_q.push_back(13'd2);
        exp_q.push_back(13'd9);
        drive_beat(2'b11, 2, 2, 1'b1);
        drive_beat(2'b00, 1, 1, 1'b1);
        drive_beat(2'b11, 3, 3, 1'b0);
        idle();
        wait_results(3, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL acc_clr_timeout: got %0d results, required 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                got = obs_q.pop_front();
                exp = exp_q.pop_front();
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL acc_clr[%0d]: got ovf=%b result=%0d, required ovf=%b result=%0d",
                             i, got[RES_W], got[RES_W-1:0], exp[RES_W], exp[RES_W-1:0]);
                end
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // Accumulator is 9 here; idle cycles with noisy fields must not disturb it.
    task automatic test_idle_inputs();
        bit ok;
        logic [RES_W:0] got;
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            mode    = 2'b11;
            input1  = WIDTH'($urandom_range(1, 15));
            input2  = WIDTH'($urandom_range(1, 15));
            acc_clr = 1'b1;
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_no_output[%0d]: out_valid got %b, required 0", c, out_valid);
            end
        end
        drive_beat(2'b11, 1, 1, 1'b0);
        idle();
        wait_results(1, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL idle_timeout: got 0 results, required 1");
        end else begin
            got = obs_q.pop_front();
            n_checks++;
            if (got !== 13'd10) begin
                n_fail++;
                $display("FAIL idle_acc: got ovf=%b result=%0d, required ovf=0 result=10",
                         got[RES_W], got[RES_W-1:0]);
            end
        end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_mul();
        test_mac_chain();
        test_back_to_back_stall();
        test_reset_midflight();
        test_acc_clr_add();
        test_idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
